// File: rtl/apb_pkg.sv
// Shared types and bus widths for the APB register-file slave.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_t;

endpackage : apb_pkg

// File: rtl/apb_regbank.sv
// DEPTH x 32-bit register storage: one synchronous write port, one
// combinational read port, whole bank cleared by synchronous reset.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [APB_DATA_W-1:0]      wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [APB_DATA_W-1:0]      rdata_o
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];
    logic [APB_DATA_W-1:0] mem_d [DEPTH];

    // Next-state of the bank: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage update; reset wipes every word so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : apb_regbank

// File: rtl/apb_slave_regfile.sv
// APB slave fronting a small register bank. Each transfer is held for a
// programmable number of wait states sampled in the setup cycle; misaligned
// or out-of-range accesses complete with pslverr_o and have no side effect.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WAIT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WAIT_W-1:0]      wait_cycles_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic [APB_ADDR_W-1:0]  paddr_i,
    input  logic                   pwrite_i,
    input  logic [APB_DATA_W-1:0]  pwdata_i,
    output logic                   pready_o,
    output logic [APB_DATA_W-1:0]  prdata_o,
    output logic                   pslverr_o
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_slv_state_t        state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    // Transfer attributes captured in the setup cycle.
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  write_q, write_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;

    logic                  setup;
    logic [IDX_W-1:0]      idx_in;
    logic                  err_in;
    logic [IDX_W-1:0]      rd_idx;
    logic [APB_DATA_W-1:0] rd_data;
    logic                  go_ready;
    logic                  eff_err;
    logic                  eff_write;
    logic                  bank_we;

    assign setup  = psel_i && !penable_i;
    assign idx_in = paddr_i[IDX_W+1:2];
    assign err_in = (paddr_i[1:0] != 2'b00) ||
                    (paddr_i >= APB_ADDR_W'(DEPTH * 4));

    // A zero-wait transfer enters READY straight from IDLE, so the read port
    // must look at the live bus address then, and at the captured one otherwise.
    assign rd_idx = (state_q == IDLE) ? idx_in : idx_q;

    // The write lands on the edge that ends READY; faulted transfers never write.
    assign bank_we = (state_q == READY) && write_q && !err_q;

    apb_regbank #(
        .DEPTH (DEPTH)
    ) u_regbank (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    // FSM next state, wait counter, setup capture and next-cycle responses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        go_ready  = 1'b0;
        eff_err   = err_q;
        eff_write = write_q;

        unique case (state_q)
            IDLE: begin
                eff_err   = err_in;
                eff_write = pwrite_i;
                if (setup) begin
                    idx_d   = idx_in;
                    err_d   = err_in;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    cnt_d   = wait_cycles_i;
                    if (wait_cycles_i == '0) begin
                        state_d  = READY;
                        go_ready = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel_i) begin
                    // Master abandoned the transfer: drop it without writing.
                    state_d = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d  = READY;
                    go_ready = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            READY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_ready) begin
            pready_d  = 1'b1;
            pslverr_d = eff_err;
            prdata_d  = (eff_err || eff_write) ? '0 : rd_data;
        end
    end

    // Control and response registers; reset returns the slave to an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Captured transfer attributes; only meaningful once a setup is accepted.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        err_q   <= err_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
    end

    assign pready_o  = pready_q;
    assign prdata_o  = prdata_q;
    assign pslverr_o = pslverr_q;

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile against a word-array reference model.
module tb_apb_slave_regfile;

    localparam int DEPTH  = 16;
    localparam int WAIT_W = 4;
    localparam int LAT_LIMIT = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [WAIT_W-1:0] wait_cycles_i;
    logic              psel_i;
    logic              penable_i;
    logic [31:0]       paddr_i;
    logic              pwrite_i;
    logic [31:0]       pwdata_i;
    logic              pready_o;
    logic [31:0]       prdata_o;
    logic              pslverr_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [DEPTH];

    apb_slave_regfile #(
        .DEPTH  (DEPTH),
        .WAIT_W (WAIT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wait_cycles_i (wait_cycles_i),
        .psel_i        (psel_i),
        .penable_i     (penable_i),
        .paddr_i       (paddr_i),
        .pwrite_i      (pwrite_i),
        .pwdata_i      (pwdata_i),
        .pready_o      (pready_o),
        .prdata_o      (prdata_o),
        .pslverr_o     (pslverr_o)
    );

    always #5 clk = ~clk;

    function automatic logic exp_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input logic wr);
        if (wr || exp_err(addr)) return 32'h0;
        return model_mem[addr / 4];
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        if (wr && !exp_err(addr)) model_mem[addr / 4] = wd;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel_i    = 1'b0;
            penable_i = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Runs one APB transfer; reports the access cycle in which pready was seen
    // (1 = first access cycle) and how many pready cycles appeared from setup on.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int waits, output logic [31:0] rd, output logic err,
                           output int lat, output int pulses);
        pulses = 0;
        rd     = 32'h0;
        err    = 1'b0;
        @(posedge clk); #1;
        if (pready_o) pulses++;
        psel_i        = 1'b1;
        penable_i     = 1'b0;
        paddr_i       = addr;
        pwrite_i      = wr;
        pwdata_i      = wd;
        wait_cycles_i = WAIT_W'(waits);
        @(posedge clk); #1;
        penable_i     = 1'b1;
        wait_cycles_i = WAIT_W'($urandom);
        lat = 1;
        while (!pready_o && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (pready_o) begin
            pulses++;
            rd  = prdata_o;
            err = pslverr_o;
        end
        model_write(addr, wr, wd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        psel_i = 1'b0; penable_i = 1'b0; paddr_i = '0; pwrite_i = 1'b0;
        pwdata_i = '0; wait_cycles_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pready_o !== 1'b0) $display("FAIL reset_pready got=%b want=0", pready_o);
        else n_pass++;
        n_checks++;
        if (prdata_o !== 32'h0) $display("FAIL reset_prdata got=%h want=0", prdata_o);
        else n_pass++;
        n_checks++;
        if (pslverr_o !== 1'b0) $display("FAIL reset_pslverr got=%b want=0", pslverr_o);
        else n_pass++;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int lat, pulses;
        do_xfer(32'h8, 1'b1, 32'hDEADBEEF, 0, rd, err, lat, pulses);
        n_checks++;
        if (lat !== 1 || pulses !== 1 || err !== 1'b0 || rd !== 32'h0)
            $display("FAIL zw_write lat=%0d pulses=%0d err=%b rd=%h want lat=1 pulses=1 err=0 rd=0",
                     lat, pulses, err, rd);
        else n_pass++;
        do_xfer(32'h8, 1'b0, 32'h0, 0, rd, err, lat, pulses);
        n_checks++;
        if (lat !== 1 || pulses !== 1 || err !== 1'b0 || rd !== exp_rdata(32'h8, 1'b0))
            $display("FAIL zw_read lat=%0d pulses=%0d err=%b rd=%h want lat=1 pulses=1 err=0 rd=%h",
                     lat, pulses, err, rd, exp_rdata(32'h8, 1'b0));
        else n_pass++;
        n_checks++;
        if (rd !== 32'hDEADBEEF) $display("FAIL zw_read_value got=%h want=deadbeef", rd);
        else n_pass++;
        bus_idle(1);
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int lat, pulses;
        apply_reset();
        do_xfer(32'h4, 1'b0, 32'h0, 3, rd, err, lat, pulses);
        n_checks++;
        if (lat !== 4 || pulses !== 1 || err !== 1'b0 || rd !== 32'h0)
            $display("FAIL wait3_read lat=%0d pulses=%0d err=%b rd=%h want lat=4 pulses=1 err=0 rd=0",
                     lat, pulses, err, rd);
        else n_pass++;
        bus_idle(1);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat, pulses;
        logic [31:0] addrs [4];
        logic        wrs   [4];
        addrs[0] = 32'h40; wrs[0] = 1'b1;
        addrs[1] = 32'h6;  wrs[1] = 1'b1;
        addrs[2] = 32'h0;  wrs[2] = 1'b0;
        addrs[3] = 32'h4;  wrs[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = $urandom_range(0, 2);
            do_xfer(addrs[i], wrs[i], $urandom, w, rd, err, lat, pulses);
            n_checks++;
            if (err !== exp_err(addrs[i]) || rd !== exp_rdata(addrs[i], wrs[i]) ||
                lat !== w + 1 || pulses !== 1)
                $display("FAIL err_case%0d addr=%h err=%b rd=%h lat=%0d pulses=%0d want err=%b rd=%h lat=%0d pulses=1",
                         i, addrs[i], err, rd, lat, pulses, exp_err(addrs[i]),
                         exp_rdata(addrs[i], wrs[i]), w + 1);
            else n_pass++;
        end
        // Misaligned read must also fault with zero data.
        do_xfer(32'h9, 1'b0, 32'h0, 1, rd, err, lat, pulses);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 2)
            $display("FAIL err_misaligned_read err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", err, rd, lat);
        else n_pass++;
        bus_idle(1);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat, pulses, seen;
        do_xfer(32'h10, 1'b1, 32'hA5A5_0001, 0, rd, err, lat, pulses);
        @(posedge clk); #1;
        seen = 0;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h10; pwrite_i = 1'b1;
        pwdata_i = 32'hBAD0_BAD0; wait_cycles_i = 4'd5;
        @(posedge clk); #1;
        penable_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (pready_o) seen++;
            @(posedge clk); #1;
        end
        if (pready_o) seen++;
        psel_i = 1'b0; penable_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (pready_o) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_pready got=%0d pulses want=0", seen);
        else n_pass++;
        do_xfer(32'h10, 1'b0, 32'h0, 2, rd, err, lat, pulses);
        n_checks++;
        if (rd !== exp_rdata(32'h10, 1'b0) || lat !== 3 || pulses !== 1)
            $display("FAIL abort_reg_unchanged rd=%h lat=%0d pulses=%0d want rd=%h lat=3 pulses=1",
                     rd, lat, pulses, exp_rdata(32'h10, 1'b0));
        else n_pass++;
        bus_idle(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat, pulses;
        do_xfer(32'hC, 1'b1, 32'h1234, 0, rd, err, lat, pulses);
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h14; pwrite_i = 1'b1;
        pwdata_i = 32'h7777_7777; wait_cycles_i = 4'd4;
        @(posedge clk); #1;
        penable_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (pready_o !== 1'b0 || prdata_o !== 32'h0 || pslverr_o !== 1'b0)
            $display("FAIL reset_mid_outputs pready=%b prdata=%h pslverr=%b want 0/0/0",
                     pready_o, prdata_o, pslverr_o);
        else n_pass++;
        reset = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        model_clear();
        do_xfer(32'hC, 1'b0, 32'h0, 0, rd, err, lat, pulses);
        n_checks++;
        if (rd !== exp_rdata(32'hC, 1'b0) || err !== 1'b0 || lat !== 1)
            $display("FAIL reset_mid_cleared_c rd=%h err=%b lat=%0d want rd=%h err=0 lat=1",
                     rd, err, lat, exp_rdata(32'hC, 1'b0));
        else n_pass++;
        do_xfer(32'h14, 1'b0, 32'h0, 1, rd, err, lat, pulses);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL reset_mid_pending_write rd=%h want=0", rd);
        else n_pass++;
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat, pulses;
        for (int p = 0; p < 10; p++) begin
            logic [31:0] addr, wd;
            int ww, wr_w;
            addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            wd   = $urandom;
            ww   = $urandom_range(1, 10);
            wr_w = $urandom_range(1, 10);
            do_xfer(addr, 1'b1, wd, ww, rd, err, lat, pulses);
            n_checks++;
            if (lat !== ww + 1 || pulses !== 1 || err !== 1'b0)
                $display("FAIL b2b_write%0d addr=%h lat=%0d pulses=%0d err=%b want lat=%0d pulses=1 err=0",
                         p, addr, lat, pulses, err, ww + 1);
            else n_pass++;
            do_xfer(addr, 1'b0, 32'h0, wr_w, rd, err, lat, pulses);
            n_checks++;
            if (rd !== exp_rdata(addr, 1'b0) || rd !== wd || lat !== wr_w + 1 ||
                pulses !== 1 || err !== 1'b0)
                $display("FAIL b2b_read%0d addr=%h rd=%h lat=%0d pulses=%0d err=%b want rd=%h lat=%0d pulses=1 err=0",
                         p, addr, rd, lat, pulses, err, wd, wr_w + 1);
            else n_pass++;
        end
        @(posedge clk); #1;
        psel_i = 1'b0; penable_i = 1'b0;
        n_checks++;
        if (pready_o !== 1'b0) $display("FAIL b2b_trailing_pready got=%b want=0", pready_o);
        else n_pass++;
        bus_idle(1);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_apb_slave_regfile
